serial_adder: RTL

Parametrised bit-serial adder/subtractor. It adds or subtracts two WIDTH-bit operands one bit per clock, LSB first, through a single full-adder slice, and signals completion with a Start/Ready/Done handshake. It is the multi-bit, clocked successor to the single-bit full adder. Use it wherever area matters more than latency, for example in accumulators and counters that tolerate WIDTH+2 cycles per operation.

---
 rtl/serial_adder_pkg.sv | 16 +
 rtl/serial_adder_full_adder_cell.sv | 13 +
 rtl/serial_adder.sv | 116 +++++++++++
 3 files changed

// File: rtl/serial_adder_pkg.sv
// Shared definitions for the bit-serial adder/subtractor: FSM state encoding
// and the bit-counter width helper.
package serial_adder_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  // Counter must hold 0..width-1; never let it collapse to zero bits.
  function automatic int cnt_w(input int width);
    return (width > 1) ? $clog2(width) : 1;
  endfunction

endpackage

// File: rtl/serial_adder_full_adder_cell.sv
// Single-bit full adder: the only arithmetic slice of the serial adder.
module full_adder_cell (
  input  logic i_a,
  input  logic i_b,
  input  logic i_cin,
  output logic o_sum,
  output logic o_carry
);

  assign o_sum   = i_a ^ i_b ^ i_cin;
  assign o_carry = (i_a & i_b) | (i_cin & (i_a ^ i_b));

endmodule

// File: rtl/serial_adder.sv
// Bit-serial adder/subtractor: one full-adder slice, LSB first, WIDTH+2 cycles
// per operation, Start/Ready/Done handshake.
module serial_adder
  import serial_adder_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_start,
  output logic             o_ready,
  input  logic             i_sub,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  input  logic             i_cin,
  output logic [WIDTH-1:0] o_sum,
  output logic             o_carry,
  output logic             o_overflow,
  output logic             o_done
);

  localparam int               CNT_W    = cnt_w(WIDTH);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

  state_t             r_state;
  state_t             w_state_nxt;
  logic [WIDTH-1:0]   r_op_a;
  logic [WIDTH-1:0]   r_op_b;
  logic [WIDTH-1:0]   r_psum;
  logic               r_carry;
  logic [CNT_W-1:0]   r_cnt;
  logic [WIDTH-1:0]   r_sum;
  logic               r_cout;
  logic               r_ovf;
  logic               w_fa_sum;
  logic               w_fa_carry;
  logic               w_last;
  logic [WIDTH-1:0]   w_psum_nxt;

  full_adder_cell u_fa (
    .i_a    (r_op_a[0]),
    .i_b    (r_op_b[0]),
    .i_cin  (r_carry),
    .o_sum  (w_fa_sum),
    .o_carry(w_fa_carry)
  );

  assign w_last     = (r_cnt == LAST_BIT);
  assign w_psum_nxt = {w_fa_sum, r_psum[WIDTH-1:1]};

  // NOTE: every variable gets a default before the case so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    w_state_nxt = r_state;
    o_ready     = 1'b0;
    o_done      = 1'b0;
    case (r_state)
      S_IDLE: begin
        o_ready = 1'b1;
        if (i_start) w_state_nxt = S_RUN;
      end
      S_RUN:  if (w_last) w_state_nxt = S_DONE;
      S_DONE: begin
        o_done      = 1'b1;
        w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge values; the datapath registers are small and all reset to 0.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= S_IDLE;
      r_op_a  <= '0;
      r_op_b  <= '0;
      r_psum  <= '0;
      r_carry <= 1'b0;
      r_cnt   <= '0;
      r_sum   <= '0;
      r_cout  <= 1'b0;
      r_ovf   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      case (r_state)
        S_IDLE: if (i_start) begin
          // Subtraction is A + ~B + 1, so Cin is replaced by the forced 1.
          r_op_a  <= i_a;
          r_op_b  <= i_sub ? ~i_b : i_b;
          r_carry <= i_sub | i_cin;
          r_cnt   <= '0;
        end
        S_RUN: begin
          r_psum  <= w_psum_nxt;
          r_carry <= w_fa_carry;
          r_op_a  <= r_op_a >> 1;
          r_op_b  <= r_op_b >> 1;
          r_cnt   <= r_cnt + 1'b1;
          if (w_last) begin
            // On the MSB slice r_carry is the carry into the MSB.
            r_sum  <= w_psum_nxt;
            r_cout <= w_fa_carry;
            r_ovf  <= r_carry ^ w_fa_carry;
          end
        end
        default: ;
      endcase
    end
  end

  assign o_sum      = r_sum;
  assign o_carry    = r_cout;
  assign o_overflow = r_ovf;

endmodule
